// File: rtl/stream_minhash_sketcher_if.sv
// Handshake bundle between the k-mer hasher array, the sketcher and the bucket/LSH stage.
// The master side is the environment (upstream source plus downstream sink); the slave side is the sketcher.
interface stream_minhash_sketcher_if #(
  parameter int unsigned SKETCH_SIZE         = 16,
  parameter int unsigned H1_WIDTH            = 32,
  parameter int unsigned H2_WIDTH            = 32,
  parameter int unsigned LOG2_NUM_OF_BUCKETS = 8,
  parameter int unsigned CNT_WIDTH           = 16
);
  logic                                        in_valid;
  logic                                        in_ready;
  logic [H1_WIDTH-1:0]                         in_h1;
  logic [H2_WIDTH-1:0]                         in_h2;
  logic                                        in_last;
  logic                                        sketch_valid;
  logic                                        sketch_ready;
  logic [SKETCH_SIZE*LOG2_NUM_OF_BUCKETS-1:0]  sketch_bucket;
  logic [SKETCH_SIZE*H1_WIDTH-1:0]             sketch_h1;
  logic [$clog2(SKETCH_SIZE+1)-1:0]            sketch_count;
  logic [CNT_WIDTH-1:0]                        kmer_count;

  modport master (
    output in_valid, in_h1, in_h2, in_last, sketch_ready,
    input  in_ready, sketch_valid, sketch_bucket, sketch_h1, sketch_count, kmer_count
  );

  modport slave (
    input  in_valid, in_h1, in_h2, in_last, sketch_ready,
    output in_ready, sketch_valid, sketch_bucket, sketch_h1, sketch_count, kmer_count
  );
endinterface

// File: rtl/stream_minhash_sketcher.sv
// Streaming bottom-S MinHash sketcher: single-pass sorted insertion of pre-hashed k-mers,
// keeping the SKETCH_SIZE smallest h1 values of a window together with their h2 buckets.
module stream_minhash_sketcher #(
  parameter int unsigned SKETCH_SIZE         = 16,
  parameter int unsigned H1_WIDTH            = 32,
  parameter int unsigned H2_WIDTH            = 32,
  parameter int unsigned LOG2_NUM_OF_BUCKETS = 8,
  parameter int unsigned DEDUP               = 1,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  stream_minhash_sketcher_if.slave bus
);
  localparam int unsigned CW = $clog2(SKETCH_SIZE + 1);
  localparam int unsigned L  = LOG2_NUM_OF_BUCKETS;

  typedef enum logic {COLLECT, DONE} state_t;

  state_t               state, state_nxt;
  logic                 started;
  logic                 in_ready, sketch_valid;
  logic                 accept, clear, dup, insert;
  logic [SKETCH_SIZE-1:0] le, le_prev;
  logic [H1_WIDTH-1:0]  h1_q  [SKETCH_SIZE];
  logic [L-1:0]         bkt_q [SKETCH_SIZE];
  logic [H1_WIDTH-1:0]  h1_sh [SKETCH_SIZE];
  logic [L-1:0]         bkt_sh[SKETCH_SIZE];
  logic [H1_WIDTH-1:0]  h1_nxt [SKETCH_SIZE];
  logic [L-1:0]         bkt_nxt[SKETCH_SIZE];
  logic [CW-1:0]        count_q;
  logic [CNT_WIDTH-1:0] kmer_q;

  // Holds in_ready low through reset until the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) started <= 1'b0;
    else          started <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    sketch_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = started;
        if (bus.in_valid && started && bus.in_last) state_nxt = DONE;
      end
      DONE: begin
        sketch_valid = 1'b1;
        if (bus.sketch_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign accept = bus.in_valid & in_ready;
  assign clear  = sketch_valid & bus.sketch_ready;

  // Parallel compare of the incoming h1 against every filled slot, and the candidate slot contents.
  // Slots are sorted, so le is a prefix mask; a slot takes the new entry where le drops from 1 to 0,
  // and its lower neighbour's contents above that point.
  always_comb begin
    dup = 1'b0;
    le  = '0;
    for (int unsigned i = 0; i < SKETCH_SIZE; i++) begin
      if (32'(count_q) > i) begin
        if (h1_q[i] == bus.in_h1) dup = 1'b1;
        le[i] = (h1_q[i] <= bus.in_h1);
      end
    end
    le_prev   = {le[SKETCH_SIZE-2:0], 1'b1};
    insert    = !((DEDUP != 0) && dup) && !le[SKETCH_SIZE-1];
    h1_sh[0]  = bus.in_h1;
    bkt_sh[0] = bus.in_h2[L-1:0];
    for (int unsigned i = 1; i < SKETCH_SIZE; i++) begin
      h1_sh[i]  = h1_q[i-1];
      bkt_sh[i] = bkt_q[i-1];
    end
    for (int unsigned i = 0; i < SKETCH_SIZE; i++) begin
      if (le[i]) begin
        h1_nxt[i]  = h1_q[i];
        bkt_nxt[i] = bkt_q[i];
      end else if (le_prev[i]) begin
        h1_nxt[i]  = bus.in_h1;
        bkt_nxt[i] = bus.in_h2[L-1:0];
      end else begin
        h1_nxt[i]  = h1_sh[i];
        bkt_nxt[i] = bkt_sh[i];
      end
    end
  end

  // Sketch slots and counters: cleared on reset and on sketch handover, updated on accepted beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SKETCH_SIZE; i++) begin
        h1_q[i]  <= '1;
        bkt_q[i] <= '0;
      end
      count_q <= '0;
      kmer_q  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < SKETCH_SIZE; i++) begin
        h1_q[i]  <= '1;
        bkt_q[i] <= '0;
      end
      count_q <= '0;
      kmer_q  <= '0;
    end else if (accept) begin
      if (kmer_q != '1) kmer_q <= kmer_q + 1'b1;
      if (insert) begin
        for (int unsigned i = 0; i < SKETCH_SIZE; i++) begin
          h1_q[i]  <= h1_nxt[i];
          bkt_q[i] <= bkt_nxt[i];
        end
        if (count_q != CW'(SKETCH_SIZE)) count_q <= count_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < SKETCH_SIZE; g++) begin : g_pack
    assign bus.sketch_h1[g*H1_WIDTH +: H1_WIDTH] = h1_q[g];
    assign bus.sketch_bucket[g*L +: L]           = bkt_q[g];
  end

  assign bus.in_ready     = in_ready;
  assign bus.sketch_valid = sketch_valid;
  assign bus.sketch_count = count_q;
  assign bus.kmer_count   = kmer_q;
endmodule

// File: tb/tb_stream_minhash_sketcher.sv
// Directed bench for stream_minhash_sketcher with SKETCH_SIZE=4: three instances share one input stream
// (DEDUP=1, DEDUP=0, and DEDUP=1 with a 4-bit k-mer counter).
module tb_stream_minhash_sketcher;
  localparam int unsigned S = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_last, sketch_ready;
  logic [31:0] in_h1, in_h2;
  int unsigned checks, errors;

  stream_minhash_sketcher_if #(.SKETCH_SIZE(S), .CNT_WIDTH(16)) bus   ();
  stream_minhash_sketcher_if #(.SKETCH_SIZE(S), .CNT_WIDTH(16)) bus0  ();
  stream_minhash_sketcher_if #(.SKETCH_SIZE(S), .CNT_WIDTH(4))  bus_s ();

  assign bus.in_valid = in_valid;     assign bus.in_h1 = in_h1;     assign bus.in_h2 = in_h2;
  assign bus.in_last = in_last;       assign bus.sketch_ready = sketch_ready;
  assign bus0.in_valid = in_valid;    assign bus0.in_h1 = in_h1;    assign bus0.in_h2 = in_h2;
  assign bus0.in_last = in_last;      assign bus0.sketch_ready = sketch_ready;
  assign bus_s.in_valid = in_valid;   assign bus_s.in_h1 = in_h1;   assign bus_s.in_h2 = in_h2;
  assign bus_s.in_last = in_last;     assign bus_s.sketch_ready = sketch_ready;

  stream_minhash_sketcher #(.SKETCH_SIZE(S), .DEDUP(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  stream_minhash_sketcher #(.SKETCH_SIZE(S), .DEDUP(0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  stream_minhash_sketcher #(.SKETCH_SIZE(S), .DEDUP(1), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [31:0] h1, input logic [31:0] h2, input logic last);
    int unsigned n;
    in_valid = 1'b1; in_h1 = h1; in_h2 = h2; in_last = last;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_sketch();
    int unsigned n;
    n = 0;
    while (!bus.sketch_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.sketch_valid !== 1'b1) begin
      errors++;
      $display("FAIL sketch_timeout sketch_valid=%b required 1", bus.sketch_valid);
    end
  endtask

  task automatic consume();
    sketch_ready = 1'b1;
    @(negedge clk);
    sketch_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.sketch_valid !== 1'b0 || bus.sketch_count !== 3'd0 ||
        bus.kmer_count !== 16'd0 || bus.sketch_h1 !== {128{1'b1}} || bus.sketch_bucket !== 32'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b cnt=%0d kmer=%0d h1=%h bkt=%h required 0 0 0 0 all-ones 0",
               bus.in_ready, bus.sketch_valid, bus.sketch_count, bus.kmer_count, bus.sketch_h1, bus.sketch_bucket);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v [6];
    v = '{50, 10, 40, 20, 30, 5};
    for (int i = 0; i < 6; i++) send(v[i], v[i] + 32'h100, i == 5);
    checks++;
    if (bus.sketch_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency sketch_valid=%b required 1", bus.sketch_valid);
    end
    wait_sketch();
    checks++;
    if (bus.sketch_h1 !== {32'd30, 32'd20, 32'd10, 32'd5} || bus.sketch_bucket !== 32'h1E140A05) begin
      errors++;
      $display("FAIL basic_sketch h1=%h bkt=%h required 0000001e000000140000000a00000005 1e140a05",
               bus.sketch_h1, bus.sketch_bucket);
    end
    checks++;
    if (bus.sketch_count !== 3'd4 || bus.kmer_count !== 16'd6 || bus_s.kmer_count !== 4'd6 ||
        bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_counts cnt=%0d kmer=%0d kmer4=%0d rdy=%b required 4 6 6 0",
               bus.sketch_count, bus.kmer_count, bus_s.kmer_count, bus.in_ready);
    end
    consume();
  endtask

  task automatic test_short();
    send(7, 7, 1'b0);
    send(3, 3, 1'b1);
    wait_sketch();
    checks++;
    if (bus.sketch_count !== 3'd2 || bus.sketch_h1 !== {32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd3} ||
        bus.sketch_bucket !== 32'h00000703) begin
      errors++;
      $display("FAIL short_window cnt=%0d h1=%h bkt=%h required 2 ffffffffffffffff0000000700000003 00000703",
               bus.sketch_count, bus.sketch_h1, bus.sketch_bucket);
    end
    consume();
  endtask

  task automatic test_dedup();
    send(9, 9, 1'b0);
    send(9, 9, 1'b0);
    send(9, 9, 1'b0);
    send(2, 2, 1'b1);
    wait_sketch();
    checks++;
    if (bus.sketch_count !== 3'd2 || bus.sketch_h1 !== {32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd2} ||
        bus.kmer_count !== 16'd4) begin
      errors++;
      $display("FAIL dedup_on cnt=%0d h1=%h kmer=%0d required 2 ffffffffffffffff0000000900000002 4",
               bus.sketch_count, bus.sketch_h1, bus.kmer_count);
    end
    checks++;
    if (bus0.sketch_count !== 3'd4 || bus0.sketch_h1 !== {32'd9, 32'd9, 32'd9, 32'd2} ||
        bus0.kmer_count !== 16'd4) begin
      errors++;
      $display("FAIL dedup_off cnt=%0d h1=%h kmer=%0d required 4 00000009000000090000000900000002 4",
               bus0.sketch_count, bus0.sketch_h1, bus0.kmer_count);
    end
    consume();
  endtask

  task automatic test_all_ones();
    send(32'hFFFFFFFF, 32'h000000AB, 1'b0);
    send(32'hFFFFFFFF, 32'h000000CD, 1'b0);
    send(1, 32'h00000011, 1'b1);
    wait_sketch();
    checks++;
    if (bus.sketch_count !== 3'd2 || bus.sketch_h1 !== {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1} ||
        bus.sketch_bucket !== 32'h0000AB11) begin
      errors++;
      $display("FAIL all_ones cnt=%0d h1=%h bkt=%h required 2 ffffffffffffffffffffffff00000001 0000ab11",
               bus.sketch_count, bus.sketch_h1, bus.sketch_bucket);
    end
    consume();
  endtask

  task automatic test_backpressure();
    send(4, 32'h104, 1'b0);
    send(8, 32'h108, 1'b0);
    send(6, 32'h106, 1'b1);
    wait_sketch();
    // Offered beats while DONE must be ignored.
    in_valid = 1'b1; in_h1 = 1; in_h2 = 1; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.sketch_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sketch_count !== 3'd3 ||
          bus.sketch_h1 !== {32'hFFFFFFFF, 32'd8, 32'd6, 32'd4} || bus.sketch_bucket !== 32'h00080604 ||
          bus.kmer_count !== 16'd3) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d vld=%b rdy=%b cnt=%0d h1=%h bkt=%h kmer=%0d required 1 0 3 ffffffff000000080000000600000004 00080604 3",
                 c, bus.sketch_valid, bus.in_ready, bus.sketch_count, bus.sketch_h1, bus.sketch_bucket, bus.kmer_count);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.sketch_valid !== 1'b0 || bus.sketch_count !== 3'd0 ||
        bus.kmer_count !== 16'd0 || bus.sketch_h1 !== {128{1'b1}} || bus.sketch_bucket !== 32'd0) begin
      errors++;
      $display("FAIL backpressure_clear rdy=%b vld=%b cnt=%0d kmer=%0d h1=%h bkt=%h required 1 0 0 0 all-ones 0",
               bus.in_ready, bus.sketch_valid, bus.sketch_count, bus.kmer_count, bus.sketch_h1, bus.sketch_bucket);
    end
  endtask

  task automatic test_midreset();
    send(1, 1, 1'b0);
    send(2, 2, 1'b0);
    send(3, 3, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.sketch_count !== 3'd0 || bus.kmer_count !== 16'd0 ||
        bus.sketch_h1 !== {128{1'b1}} || bus.sketch_bucket !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async rdy=%b cnt=%0d kmer=%0d h1=%h bkt=%h required 0 0 0 all-ones 0",
               bus.in_ready, bus.sketch_count, bus.kmer_count, bus.sketch_h1, bus.sketch_bucket);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(200, 32'hC8, 1'b0);
    send(100, 32'h64, 1'b1);
    wait_sketch();
    checks++;
    if (bus.sketch_count !== 3'd2 || bus.kmer_count !== 16'd2 ||
        bus.sketch_h1 !== {32'hFFFFFFFF, 32'hFFFFFFFF, 32'd200, 32'd100} || bus.sketch_bucket !== 32'h0000C864) begin
      errors++;
      $display("FAIL midreset_next cnt=%0d kmer=%0d h1=%h bkt=%h required 2 2 ffffffffffffffff000000c800000064 0000c864",
               bus.sketch_count, bus.kmer_count, bus.sketch_h1, bus.sketch_bucket);
    end
    consume();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) send(32'(100 - i), 32'(i), i == 19);
    wait_sketch();
    checks++;
    if (bus_s.kmer_count !== 4'hF || bus.kmer_count !== 16'd20 ||
        bus.sketch_h1 !== {32'd84, 32'd83, 32'd82, 32'd81} || bus.sketch_bucket !== 32'h10111213) begin
      errors++;
      $display("FAIL saturation kmer4=%0d kmer16=%0d h1=%h bkt=%h required 15 20 00000054000000530000005200000051 10111213",
               bus_s.kmer_count, bus.kmer_count, bus.sketch_h1, bus.sketch_bucket);
    end
    consume();
  endtask

  logic [31:0] wh1 [40];
  logic [31:0] wh2 [40];

  task automatic test_back_to_back();
    int unsigned len, ecount;
    longint      prev, best;
    int          bi;
    logic [127:0] eh1;
    logic [31:0]  eb;
    logic [3:0]   ek;
    for (int w = 0; w < 30; w++) begin
      len = $urandom_range(1, 40);
      for (int j = 0; j < int'(len); j++) begin
        wh1[j] = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 63));
        wh2[j] = $urandom;
      end
      for (int j = 0; j < int'(len); j++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(wh1[j], wh2[j], j == int'(len) - 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      // Reference: successive distinct minima; bucket from the first occurrence of each value.
      eh1 = '1; eb = '0; ecount = 0; prev = -1;
      for (int k = 0; k < int'(S); k++) begin
        best = 64'h1_0000_0000; bi = -1;
        for (int j = 0; j < int'(len); j++) begin
          if (longint'(wh1[j]) > prev && longint'(wh1[j]) < best) begin
            best = longint'(wh1[j]); bi = j;
          end
        end
        if (bi >= 0) begin
          eh1[k*32 +: 32] = wh1[bi];
          eb[k*8 +: 8]    = wh2[bi][7:0];
          ecount++;
          prev = best;
        end
      end
      ek = (len > 15) ? 4'hF : 4'(len);
      wait_sketch();
      checks++;
      if (bus.sketch_h1 !== eh1 || bus.sketch_bucket !== eb || bus.sketch_count !== 3'(ecount) ||
          bus.kmer_count !== 16'(len) || bus_s.kmer_count !== ek) begin
        errors++;
        $display("FAIL window_%0d h1=%h bkt=%h cnt=%0d kmer=%0d kmer4=%0d required %h %h %0d %0d %0d",
                 w, bus.sketch_h1, bus.sketch_bucket, bus.sketch_count, bus.kmer_count, bus_s.kmer_count,
                 eh1, eb, ecount, len, ek);
      end
      consume();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; sketch_ready = 1'b0;
    in_h1 = '0; in_h2 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_short();
    test_dedup();
    test_all_ones();
    test_backpressure();
    test_midreset();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
